sm4_req_arb: RTL

SM4_REQ_ARB -- requirements
Module: sm4_req_arb

---
 rtl/sm4_req_arb_pkg.sv | 14 +
 rtl/sm4_req_arb_if.sv | 30 +++
 rtl/sm4_rr_arb.sv | 49 ++++
 rtl/sm4_req_arb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sm4_req_arb_pkg.sv
// sm4_pkg: shared constants and FSM state type for the SM4 request arbiter.
package sm4_pkg;

  localparam int unsigned SM4_BLK_W = 128;
  localparam int unsigned SM4_TMO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sm4_state_e;

endpackage

// File: rtl/sm4_req_arb_if.sv
// sm4_req_arb_if: requester-side request/response handshakes plus the
// start/done link to the shared SM4 core. slave = arbiter, master = the
// environment (requesters and core).
interface sm4_req_arb_if;
  import sm4_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [2*SM4_BLK_W-1:0] req_data;
  logic [1:0]             req_dec;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [SM4_BLK_W-1:0]   rsp_data;
  logic                   core_start;
  logic                   core_dec;
  logic [SM4_BLK_W-1:0]   core_din;
  logic                   core_done;
  logic [SM4_BLK_W-1:0]   core_dout;

  modport slave (
    input  req_valid, req_data, req_dec, rsp_ready, core_done, core_dout,
    output req_ready, rsp_valid, rsp_data, core_start, core_dec, core_din
  );

  modport master (
    output req_valid, req_data, req_dec, rsp_ready, core_done, core_dout,
    input  req_ready, rsp_valid, rsp_data, core_start, core_dec, core_din
  );

endinterface

// File: rtl/sm4_rr_arb.sv
// sm4_rr_arb: 2-way combinational grant.
// SM4_ARB_RR_EN defined   -> round-robin with a one-bit pointer register.
// SM4_ARB_RR_EN undefined -> fixed priority, requester 0 wins ties.
module sm4_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_owner,
  output logic [1:0] grant
);

`ifdef SM4_ARB_RR_EN
  logic ptr;

  // Pointer names the tie winner; it moves past whoever was just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~last_owner;
    end
  end

  // Grant the pointed-to requester if it asks, otherwise the other one.
  always_comb begin
    grant = '0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, advance, last_owner};

  // Requester 0 always wins a tie.
  always_comb begin
    grant = '0;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/sm4_req_arb.sv
// sm4_req_arb: shares one SM4 core between two requesters, one operation
// outstanding at a time, with a WAIT-state timeout that sets a sticky err.
// Arbitration policy selected by macro SM4_ARB_RR_EN (see sm4_rr_arb).
module sm4_req_arb
  import sm4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_ready,
  sm4_req_arb_if.slave bus,
  output logic         busy,
  output logic         err
);

  localparam logic [SM4_TMO_W-1:0] TMO_LAST = SM4_TMO_W'(TIMEOUT - 1);

  sm4_state_e           state;
  sm4_state_e           state_n;
  logic [SM4_TMO_W-1:0] cnt;
  logic                 owner;
  logic [1:0]           grant;
  logic                 accept;
  logic                 done_ok;
  logic                 timeout;
  logic                 rsp_taken;
  logic [SM4_BLK_W-1:0] sel_data;
  logic                 sel_dec;

  sm4_rr_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.req_valid),
    .advance    (rsp_taken | timeout),
    .last_owner (owner),
    .grant      (grant)
  );

  assign sel_data = grant[1] ? bus.req_data[2*SM4_BLK_W-1:SM4_BLK_W]
                             : bus.req_data[SM4_BLK_W-1:0];
  assign sel_dec  = grant[1] ? bus.req_dec[1] : bus.req_dec[0];
  assign busy     = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n        = state;
    accept         = 1'b0;
    done_ok        = 1'b0;
    timeout        = 1'b0;
    rsp_taken      = 1'b0;
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.core_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rst && key_ready && (bus.req_valid != 2'b00)) begin
          bus.req_ready = grant;
          accept        = 1'b1;
          state_n       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.core_start = 1'b1;
        state_n        = ST_WAIT;
      end
      ST_WAIT: begin
        // done wins over the last counted cycle, so a completion that lands
        // exactly on the timeout boundary is still a completion.
        if (bus.core_done) begin
          done_ok = 1'b1;
          state_n = ST_RESP;
        end else if (cnt == TMO_LAST) begin
          timeout = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = owner ? 2'b10 : 2'b01;
        if (bus.rsp_ready[owner]) begin
          rsp_taken = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Latched request, WAIT counter, response data and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= 1'b0;
      bus.core_din <= '0;
      bus.core_dec <= 1'b0;
      bus.rsp_data <= '0;
      cnt          <= '0;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        owner        <= grant[1];
        bus.core_din <= sel_data;
        bus.core_dec <= sel_dec;
      end
      if (state == ST_ISSUE) begin
        cnt <= '0;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + SM4_TMO_W'(1);
      end
      if (done_ok) begin
        bus.rsp_data <= bus.core_dout;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule
